// File: rtl/dpi_trace_pkg.sv
// Purpose: shared types, constants and helpers for the commit-trace buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dpi_trace_pkg;

   // Entry field widths; the top-level XLEN/SEQ_W parameters default to these.
   localparam int TRACE_XLEN  = 32;
   localparam int TRACE_SEQ_W = 32;
   localparam int DROP_CNT_W  = 16;

   // One buffered retire record.
   typedef struct packed {
      logic [TRACE_XLEN-1:0]  pc;
      logic [TRACE_XLEN-1:0]  nextpc;
      logic [TRACE_XLEN-1:0]  inst;
      logic [TRACE_SEQ_W-1:0] seq;
   } trace_entry_t;

   // Number of set bits in a vector of up to four commit channels.
   function automatic logic [2:0] popcount4(input logic [3:0] v);
      popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/dpi_commit_trace_commit_compactor.sv
// Purpose: rank valid commit channels into consecutive write offsets and split them into accept/drop.
// Latency: purely combinational.
// Backpressure: lowest-index valid channels are accepted up to the free-slot count; the rest are dropped.
module commit_compactor
   import dpi_trace_pkg::*;
#(
   parameter int NR_COMMIT = 2,
   parameter int CNT_W     = 4
) (
   input  logic [NR_COMMIT-1:0]      valid,
   input  logic [CNT_W-1:0]          free,
   output logic [NR_COMMIT-1:0][2:0] rank,
   output logic [NR_COMMIT-1:0]      accept,
   output logic [2:0]                n_accept,
   output logic [2:0]                n_drop
);

   logic [2:0] k;
   logic [2:0] run;

   // Prefix-count valid channels: each valid channel's rank is the number of valid channels below it.
   always_comb begin
      run    = '0;
      rank   = '0;
      accept = '0;
      for (int i = 0; i < NR_COMMIT; i++) begin
         rank[i] = run;
         if (valid[i]) begin
            accept[i] = (int'(run) < int'(free));
            run       = run + 3'd1;
         end
      end
   end

   // Accepted count is min(k, free); anything beyond that is dropped.
   always_comb begin
      k        = popcount4(4'(valid));
      n_accept = (int'(k) <= int'(free)) ? k : 3'(free);
      n_drop   = k - n_accept;
   end

endmodule

// File: rtl/dpi_commit_trace.sv
// Purpose: compact up to NR_COMMIT retired instructions per cycle into a sequence-tagged trace FIFO.
// Latency: an entry written into an empty FIFO appears on trace_valid the cycle after its commit edge.
// Backpressure: trace_valid/trace_ready drain; almost_full asks the core to stall; excess commits are dropped and counted.
module dpi_commit_trace
   import dpi_trace_pkg::*;
#(
   parameter int XLEN      = TRACE_XLEN,
   parameter int NR_COMMIT = 2,
   parameter int DEPTH     = 8,
   parameter int SEQ_W     = TRACE_SEQ_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NR_COMMIT-1:0]      commit_valid,
   input  logic [NR_COMMIT*XLEN-1:0] commit_pc,
   input  logic [NR_COMMIT*XLEN-1:0] commit_nextpc,
   input  logic [NR_COMMIT*XLEN-1:0] commit_inst,
   output logic                      trace_valid,
   input  logic                      trace_ready,
   output logic [XLEN-1:0]           trace_pc,
   output logic [XLEN-1:0]           trace_nextpc,
   output logic [XLEN-1:0]           trace_inst,
   output logic [SEQ_W-1:0]          trace_seq,
   output logic                      almost_full,
   output logic                      overflow,
   output logic [DROP_CNT_W-1:0]     drop_cnt
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int DSUM_W = DROP_CNT_W + 1;

   trace_entry_t mem [DEPTH];

   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      count_next;
   logic [CNT_W-1:0]      free;
   logic [SEQ_W-1:0]      next_seq;
   logic                  almost_full_q;
   logic                  overflow_q;
   logic [DROP_CNT_W-1:0] drop_cnt_q;
   logic [DSUM_W-1:0]     drop_sum;
   logic                  deq;

   logic [NR_COMMIT-1:0][2:0] rank;
   logic [NR_COMMIT-1:0]      accept;
   logic [2:0]                n_accept;
   logic [2:0]                n_drop;
   trace_entry_t              entry_in [NR_COMMIT];
   trace_entry_t              head;

   // Room is judged on the pre-dequeue occupancy, so a same-cycle pop never frees a slot for this cycle's commits.
   assign free = CNT_W'(DEPTH) - count;
   assign deq  = trace_valid && trace_ready;

   commit_compactor #(
      .NR_COMMIT (NR_COMMIT),
      .CNT_W     (CNT_W)
   ) u_compactor (
      .valid    (commit_valid),
      .free     (free),
      .rank     (rank),
      .accept   (accept),
      .n_accept (n_accept),
      .n_drop   (n_drop)
   );

   // Unpack each channel and tag it with the sequence number its rank would receive.
   always_comb begin
      for (int i = 0; i < NR_COMMIT; i++) begin
         entry_in[i]        = '0;
         entry_in[i].pc     = commit_pc[i*XLEN +: XLEN];
         entry_in[i].nextpc = commit_nextpc[i*XLEN +: XLEN];
         entry_in[i].inst   = commit_inst[i*XLEN +: XLEN];
         entry_in[i].seq    = next_seq + SEQ_W'(rank[i]);
      end
   end

   // Next occupancy and the saturating drop accumulator.
   always_comb begin
      count_next = count + CNT_W'(n_accept) - CNT_W'(deq);
      drop_sum   = {1'b0, drop_cnt_q} + DSUM_W'(n_drop);
   end

   // Storage writes: accepted channels land in consecutive slots from wr_ptr; no reset needed since reads are gated by count.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NR_COMMIT; i++) begin
            if (accept[i]) begin
               mem[wr_ptr + PTR_W'(rank[i])] <= entry_in[i];
            end
         end
      end
   end

   // Pointers, occupancy, sequence counter and status flags; reset wins over any concurrent push or pop.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         next_seq      <= '0;
         almost_full_q <= 1'b0;
         overflow_q    <= 1'b0;
         drop_cnt_q    <= '0;
      end else begin
         wr_ptr        <= wr_ptr + PTR_W'(n_accept);
         rd_ptr        <= rd_ptr + PTR_W'(deq);
         count         <= count_next;
         next_seq      <= next_seq + SEQ_W'(n_accept);
         almost_full_q <= (int'(count_next) >= (DEPTH - NR_COMMIT));
         if (n_drop != 3'd0) begin
            overflow_q <= 1'b1;
            drop_cnt_q <= drop_sum[DSUM_W-1] ? {DROP_CNT_W{1'b1}} : drop_sum[DROP_CNT_W-1:0];
         end
      end
   end

   // Head entry is read straight from storage and forced to zero while the FIFO is empty.
   always_comb begin
      head         = mem[rd_ptr];
      trace_valid  = (count != '0);
      trace_pc     = trace_valid ? head.pc     : '0;
      trace_nextpc = trace_valid ? head.nextpc : '0;
      trace_inst   = trace_valid ? head.inst   : '0;
      trace_seq    = trace_valid ? head.seq    : '0;
      almost_full  = almost_full_q;
      overflow     = overflow_q;
      drop_cnt     = drop_cnt_q;
   end

endmodule

// File: tb/tb_dpi_commit_trace.sv
// Purpose: directed self-checking bench for dpi_commit_trace (NR_COMMIT=2, DEPTH=8).
// Latency: inputs change 1ns after a rising edge; outputs are sampled at the same point.
// Backpressure: trace_ready is driven per vector to exercise hold, drain and overflow.
module tb_dpi_commit_trace;

   logic        clock;
   logic        reset;
   logic [1:0]  commit_valid;
   logic [63:0] commit_pc;
   logic [63:0] commit_nextpc;
   logic [63:0] commit_inst;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_pc;
   logic [31:0] trace_nextpc;
   logic [31:0] trace_inst;
   logic [31:0] trace_seq;
   logic        almost_full;
   logic        overflow;
   logic [15:0] drop_cnt;

   int errors = 0;
   int checks = 0;

   dpi_commit_trace #(
      .XLEN      (32),
      .NR_COMMIT (2),
      .DEPTH     (8),
      .SEQ_W     (32)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .commit_valid  (commit_valid),
      .commit_pc     (commit_pc),
      .commit_nextpc (commit_nextpc),
      .commit_inst   (commit_inst),
      .trace_valid   (trace_valid),
      .trace_ready   (trace_ready),
      .trace_pc      (trace_pc),
      .trace_nextpc  (trace_nextpc),
      .trace_inst    (trace_inst),
      .trace_seq     (trace_seq),
      .almost_full   (almost_full),
      .overflow      (overflow),
      .drop_cnt      (drop_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  v;
      logic [31:0] pc0;
      logic [31:0] pc1;
      logic        rdy;
      logic        e_vld;
      logic [31:0] e_pc;
      logic [31:0] e_seq;
      logic        e_af;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // nextpc = pc+4 and inst = pc^0x13 on every channel, so the head can be checked from its pc alone.
   task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1, input logic rdy);
      commit_valid  = v;
      commit_pc     = {pc1, pc0};
      commit_nextpc = {pc1 + 32'd4, pc0 + 32'd4};
      commit_inst   = {pc1 ^ 32'h13, pc0 ^ 32'h13};
      trace_ready   = rdy;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_head(input string name, input logic [31:0] pc, input logic [31:0] seq);
      check({name, " valid"}, 64'(trace_valid), 64'(1));
      check({name, " pc"}, 64'(trace_pc), 64'(pc));
      check({name, " nextpc"}, 64'(trace_nextpc), 64'(pc + 32'd4));
      check({name, " inst"}, 64'(trace_inst), 64'(pc ^ 32'h13));
      check({name, " seq"}, 64'(trace_seq), 64'(seq));
   endtask

   task automatic check_idle(input string name);
      check({name, " valid"}, 64'(trace_valid), 64'(0));
      check({name, " pc"}, 64'(trace_pc), 64'(0));
      check({name, " seq"}, 64'(trace_seq), 64'(0));
      check({name, " af"}, 64'(almost_full), 64'(0));
      check({name, " ovf"}, 64'(overflow), 64'(0));
      check({name, " drop"}, 64'(drop_cnt), 64'(0));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(2'b00, 32'h0, 32'h0, 1'b0);
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      // Single commit, sparse channel, hold-while-not-ready, simultaneous push/pop, drain to empty.
      tbl[0] = '{2'b01, 32'h8000_0000, 32'h0,   1'b1, 1'b1, 32'h8000_0000, 32'd0, 1'b0};
      tbl[1] = '{2'b00, 32'h0,         32'h0,   1'b1, 1'b0, 32'h0,         32'd0, 1'b0};
      tbl[2] = '{2'b10, 32'h111,       32'h200, 1'b1, 1'b1, 32'h200,       32'd1, 1'b0};
      tbl[3] = '{2'b11, 32'h300,       32'h304, 1'b0, 1'b1, 32'h200,       32'd1, 1'b0};
      tbl[4] = '{2'b00, 32'h0,         32'h0,   1'b1, 1'b1, 32'h300,       32'd2, 1'b0};
      tbl[5] = '{2'b00, 32'h0,         32'h0,   1'b1, 1'b1, 32'h304,       32'd3, 1'b0};
      tbl[6] = '{2'b01, 32'h400,       32'h0,   1'b1, 1'b1, 32'h400,       32'd4, 1'b0};
      tbl[7] = '{2'b00, 32'h0,         32'h0,   1'b1, 1'b0, 32'h0,         32'd0, 1'b0};

      do_reset();
      check_idle("reset");

      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].v, tbl[i].pc0, tbl[i].pc1, tbl[i].rdy);
         step();
         check($sformatf("vec%0d valid", i), 64'(trace_valid), 64'(tbl[i].e_vld));
         check($sformatf("vec%0d pc", i), 64'(trace_pc), 64'(tbl[i].e_pc));
         check($sformatf("vec%0d nextpc", i), 64'(trace_nextpc),
               64'(tbl[i].e_vld ? tbl[i].e_pc + 32'd4 : 32'd0));
         check($sformatf("vec%0d seq", i), 64'(trace_seq), 64'(tbl[i].e_seq));
         check($sformatf("vec%0d af", i), 64'(almost_full), 64'(tbl[i].e_af));
      end

      // Dual commit with ready low for three cycles, then drain in order.
      do_reset();
      for (int c = 0; c < 3; c++) begin
         drive(2'b11, 32'h100 + 32'(8 * c), 32'h104 + 32'(8 * c), 1'b0);
         step();
         check($sformatf("dual af c%0d", c), 64'(almost_full), 64'(c == 2));
      end
      drive(2'b00, 32'h0, 32'h0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         check_head($sformatf("dual drain%0d", k), 32'h100 + 32'(4 * k), 32'(k));
         step();
         if (k == 0) check("dual af after pop", 64'(almost_full), 64'(0));
      end
      check("dual empty", 64'(trace_valid), 64'(0));

      // Fill to 7, overflow on a dual commit, then push-at-full with a concurrent pop.
      do_reset();
      for (int c = 0; c < 3; c++) begin
         drive(2'b11, 32'h100 + 32'(8 * c), 32'h104 + 32'(8 * c), 1'b0);
         step();
      end
      drive(2'b01, 32'h118, 32'h0, 1'b0);
      step();
      check("fill7 af", 64'(almost_full), 64'(1));
      check("fill7 ovf", 64'(overflow), 64'(0));
      drive(2'b11, 32'hA00, 32'hA04, 1'b0);
      step();
      check("ovf flag", 64'(overflow), 64'(1));
      check("ovf drop", 64'(drop_cnt), 64'(1));
      check_head("ovf head", 32'h100, 32'd0);
      drive(2'b01, 32'hB00, 32'h0, 1'b1);
      step();
      check("full push drop", 64'(drop_cnt), 64'(2));
      check("full push af", 64'(almost_full), 64'(1));
      drive(2'b00, 32'h0, 32'h0, 1'b1);
      for (int k = 0; k < 7; k++) begin
         check_head($sformatf("ovf drain%0d", k), (k < 6) ? 32'h104 + 32'(4 * k) : 32'hA00, 32'(k + 1));
         step();
      end
      check("ovf empty", 64'(trace_valid), 64'(0));
      check("ovf sticky", 64'(overflow), 64'(1));
      check("ovf drop hold", 64'(drop_cnt), 64'(2));
      drive(2'b01, 32'hC00, 32'h0, 1'b0);
      step();
      check_head("seq after drop", 32'hC00, 32'd8);

      // Build count=5 with overflow set, then reset with commits pending.
      for (int c = 0; c < 2; c++) begin
         drive(2'b11, 32'hC10 + 32'(8 * c), 32'hC14 + 32'(8 * c), 1'b0);
         step();
      end
      check("cnt5 af", 64'(almost_full), 64'(0));
      check("cnt5 ovf", 64'(overflow), 64'(1));
      reset = 1'b1;
      drive(2'b11, 32'hE00, 32'hE04, 1'b1);
      step();
      reset = 1'b0;
      check_idle("mid reset");
      drive(2'b01, 32'hD00, 32'h0, 1'b0);
      step();
      check_head("post reset", 32'hD00, 32'd0);
      check("post reset drop", 64'(drop_cnt), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dpi_commit_trace.md
Name: dpi_commit_trace

Overview:
- Multi-channel commit-trace buffer between the core's retire stage and the simulation environment.
- Each cycle it captures up to NR_COMMIT retired instructions (pc, nextpc, inst) and compacts them in channel order.
- Entries are tagged with a sequence number, buffered in a circular FIFO, and drained one per cycle through a valid/ready port.
- It provides an almost-full signal so the core can stall, and it accounts for dropped entries, so an invalid or blocked cycle never reaches the environment.

Parameters:
- XLEN, 32, width of pc/nextpc/inst.
- NR_COMMIT, 2, number of commit channels; legal range 1..4.
- DEPTH, 8, FIFO entries; power of two, DEPTH >= 2*NR_COMMIT.
- SEQ_W, 32, sequence-number width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- commit_valid  in  NR_COMMIT  per-channel retire valid.
- commit_pc  in  NR_COMMIT*XLEN  channel i at bits [i*XLEN +: XLEN].
- commit_nextpc  in  NR_COMMIT*XLEN  same packing as commit_pc.
- commit_inst  in  NR_COMMIT*XLEN  same packing as commit_pc.
- trace_valid  out  1  head entry available.
- trace_ready  in  1  consumer accepts head.
- trace_pc  out  XLEN  head pc.
- trace_nextpc  out  XLEN  head nextpc.
- trace_inst  out  XLEN  head inst.
- trace_seq  out  SEQ_W  head sequence number.
- almost_full  out  1  count >= DEPTH-NR_COMMIT; core should stall retire.
- overflow  out  1  sticky; set on the first drop.
- drop_cnt  out  16  saturating count of dropped entries.

Behaviour:
- Reset: clear all registers. Outputs go to trace_valid=0, almost_full=0, overflow=0, drop_cnt=0, trace_* data=0, and the next sequence number = 0. Reset takes priority over any concurrent enqueue or dequeue; entries in flight at reset are discarded without being counted as drops.
- Enqueue: k = popcount(commit_valid).
  - Valid channels are written in ascending channel index to consecutive slots starting at wr_ptr.
  - Each written entry gets seq = next_seq + its rank (0..k-1); next_seq then advances by the number accepted.
  - Sequence numbers wrap modulo 2^SEQ_W.
- Free slots: free = DEPTH - count, evaluated before this cycle's dequeue. A dequeue in the same cycle does not create extra room.
- Overflow (k > free): accept the lowest-index valid channels up to free; drop the remainder.
  - Set overflow; add the dropped count to drop_cnt, saturating at 16'hFFFF.
  - Dropped entries consume no sequence numbers.
- Dequeue: a transfer occurs when trace_valid && trace_ready. On a transfer, rd_ptr advances by 1 and count decreases by 1.
  - trace_* reflect the head entry combinationally from FIFO storage and hold stable while trace_valid && !trace_ready.
- Latency: an entry enqueued at clock edge N is visible on trace_valid in the cycle following edge N, when the FIFO was empty.
- Simultaneous enqueue and dequeue: count_next = count + accepted - deq. Both pointers wrap modulo DEPTH.
- Status flags:
  - trace_valid = (count != 0).
  - almost_full is a registered function of count_next.
- Widths: count is $clog2(DEPTH+1) bits; pointers are $clog2(DEPTH) bits.
- Entries are never reordered or duplicated. Empty-cycle reads have no effect.

Optional Feature:
- Macro: DPI_COMMIT_TRACE_CALL_EN.
- Defined: on every transfer, the block calls the imported DPI function get_info(pc, nextpc, inst, 1) from a clocked block, only when reset is low.
- Defined: if the environment has no separate consumer, tie trace_ready to 1.
- Undefined: no DPI import; the block is pure RTL and the trace is observed only on the ports.

Decomposition:
- Shared package dpi_trace_pkg holds:
  - typedef trace_entry_t {pc, nextpc, inst, seq};
  - DROP_CNT_W = 16;
  - a popcount function for NR_COMMIT <= 4.
- One natural sub-module, commit_compactor: combinational ranking of valid channels into write offsets plus accept/drop masks given free.
- The FIFO stays in the top level.

Test Plan:
- Single channel, NR_COMMIT=2, DEPTH=8, trace_ready=1: commit_valid=2'b01, pc=0x80000000 at edge 0 → trace_valid=1 in the next cycle with trace_pc=0x80000000 and trace_seq=0.
- Dual commit with ready held low: channels 1 and 0 both valid (pc 0x100 on ch0, 0x104 on ch1) for 3 cycles → count=6 and almost_full=1. Release ready → drain order 0x100, 0x104, ... with seq 0..5.
- Overflow: ready=0, fill 7 entries, then commit_valid=2'b11 → ch0 accepted and ch1 dropped; overflow=1, drop_cnt=1, count=8, next seq=8.
- Sparse channels: commit_valid=2'b10 only → entry written from ch1 data; no hole in the FIFO or in the seq sequence.
- Simultaneous enqueue and dequeue at count=8 with k=1, ready=1 → the entry is dropped (free evaluated pre-dequeue); count becomes 7 and drop_cnt increments.
- Reset mid-operation: count=5 and overflow=1, assert reset for 1 cycle → all outputs 0. A subsequent commit gets seq=0.
